// File: rtl/uart_sample_streamer_pkg.sv
// uart_sample_streamer_pkg: shared FSM encoding, frame constants and byte selection
package uart_sample_streamer_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO} state_t;
  localparam int FRAME_LEN = 5;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [7:0] sync,
                                            input logic [7:0] seq, input logic [15:0] s);
    return i == 3'd0 ? sync :
           i == 3'd1 ? seq :
           i == 3'd2 ? s[15:8] :
           i == 3'd3 ? s[7:0] : seq ^ s[15:8] ^ s[7:0];
  endfunction
endpackage

// File: rtl/uart_sample_streamer_fifo.sv
// sample_fifo: synchronous FIFO with head-of-queue read and occupancy level
module sample_fifo #(
  parameter int W = 16,
  parameter int D = 16,
  localparam int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(D);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      level <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_sample_streamer.sv
// uart_sample_streamer: frames FIFO-buffered samples into 5-byte UART packets
module uart_sample_streamer
  import uart_sample_streamer_pkg::*;
#(
  parameter int          C_SAMPLE_WIDTH = 16,
  parameter int          C_FIFO_DEPTH   = 16,
  parameter logic [7:0]  C_SYNC_BYTE    = SYNC_BYTE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            sampleValid,
  input  logic [C_SAMPLE_WIDTH-1:0]       sampleData,
  input  logic                            txBusy,
  input  logic                            txErr,
  output logic                            txSend,
  output logic [7:0]                      txData,
  output logic [$clog2(C_FIFO_DEPTH):0]   fifoLevel,
  output logic [7:0]                      dropCount,
  output logic                            overflow,
  output logic                            errFlag
);
  state_t state, next;
  logic [2:0] idx;
  logic [7:0] seq;
  logic [C_SAMPLE_WIDTH-1:0] frame, head;
  logic full, empty, push, drop, last, done;
  assign push = sampleValid && enable && !full;
  assign drop = sampleValid && enable && full;
  assign last = idx == 3'(FRAME_LEN - 1);
  assign done = state == WAIT_LO && !txBusy;
  sample_fifo #(.W(C_SAMPLE_WIDTH), .D(C_FIFO_DEPTH)) fifo (
    .clk(clk), .rst(rst), .push(push), .pop(state == LOAD), .din(sampleData),
    .dout(head), .full(full), .empty(empty), .level(fifoLevel)
  );
  always_comb begin
    next = state;
    txSend = state == SEND && !txBusy;
    case (state)
      IDLE:    next = empty ? IDLE : LOAD;
      LOAD:    next = SEND;
      SEND:    next = txBusy ? SEND : WAIT_HI;
      WAIT_HI: next = txBusy ? WAIT_LO : WAIT_HI;
      WAIT_LO: next = txBusy ? WAIT_LO : !last ? SEND : empty ? IDLE : LOAD;
      default: next = IDLE;
    endcase
  end
  // txData is registered so it holds from the send strobe until the next byte is chosen
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      seq <= '0;
      frame <= '0;
      txData <= '0;
      dropCount <= '0;
      overflow <= 1'b0;
      errFlag <= 1'b0;
    end else begin
      state <= next;
      if (state == LOAD) begin
        frame <= head;
        idx <= '0;
        txData <= C_SYNC_BYTE;
      end
      if (done && !last) begin
        idx <= idx + 3'd1;
        txData <= frame_byte(idx + 3'd1, C_SYNC_BYTE, seq, frame);
      end
      if (done && last) seq <= seq + 8'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
      end
      if (txErr) errFlag <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_sample_streamer.sv
// tb_uart_sample_streamer: scoreboard bench with a busy-pulse UART_Tx model
module tb_uart_sample_streamer;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, sampleValid = 1'b0, txErr = 1'b0, hold_busy = 1'b0;
  logic [15:0] sampleData = '0;
  logic txSend, txBusy, overflow, errFlag;
  logic [7:0] txData, dropCount, exp_b;
  logic [4:0] fifoLevel;
  logic [7:0] exp_q[$];
  logic [7:0] exp_seq = '0;
  int busy_cnt = 0, errors = 0, checks = 0, sends = 0;

  uart_sample_streamer dut (
    .clk(clk), .rst(rst), .enable(enable), .sampleValid(sampleValid), .sampleData(sampleData),
    .txBusy(txBusy), .txErr(txErr), .txSend(txSend), .txData(txData), .fifoLevel(fifoLevel),
    .dropCount(dropCount), .overflow(overflow), .errFlag(errFlag)
  );

  always #5 clk = ~clk;
  // UART_Tx stand-in: busy for 10 cycles starting at the edge that takes the send strobe
  assign txBusy = hold_busy || busy_cnt != 0;
  always @(posedge clk) busy_cnt <= rst ? 0 : txSend ? 10 : busy_cnt > 0 ? busy_cnt - 1 : 0;

  always @(negedge clk) begin
    if (!rst && txSend) begin
      sends++;
      checks++;
      if (txBusy) begin
        errors++;
        $display("FAIL send_while_busy: txBusy=%b, required 0", txBusy);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL txData: got %h, required no send", txData);
      end else begin
        exp_b = exp_q.pop_front();
        if (txData !== exp_b) begin
          errors++;
          $display("FAIL txData: got %h, required %h", txData, exp_b);
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] d);
    exp_q.push_back(8'hA5);
    exp_q.push_back(exp_seq);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(exp_seq ^ d[15:8] ^ d[7:0]);
    exp_seq++;
  endtask

  task automatic strobe(input logic [15:0] d, input bit acc);
    sampleValid = 1'b1;
    sampleData = d;
    if (acc) push_exp(d);
    @(negedge clk);
    sampleValid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_seq = '0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fifoLevel != 0 || txBusy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (15) @(negedge clk);
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain: %0d bytes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic wait_sends(input int target, input int budget);
    int n = 0;
    while (sends < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sends < target) begin
      errors++;
      $display("FAIL wait_sends: got %0d, required %0d", sends, target);
    end
  endtask

  task automatic check_count(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_count("reset_txSend", int'(txSend), 0);
    check_count("reset_txData", int'(txData), 0);
    check_count("reset_fifoLevel", int'(fifoLevel), 0);
    check_count("reset_dropCount", int'(dropCount), 0);
    check_count("reset_overflow", int'(overflow), 0);
    check_count("reset_errFlag", int'(errFlag), 0);
  endtask

  task automatic test_single();
    int base = sends;
    enable = 1'b1;
    strobe(16'h1234, 1'b1);
    check_count("single_level_n", int'(fifoLevel), 1);
    check_count("single_send_n", int'(txSend), 0);
    @(negedge clk);
    check_count("single_send_n1", int'(txSend), 0);
    @(negedge clk);
    check_count("single_send_n2", int'(txSend), 1);
    check_count("single_sync_n2", int'(txData), 8'hA5);
    drain(200);
    check_count("single_sends", sends - base, 5);
  endtask

  task automatic test_txerr();
    int base = sends;
    strobe(16'hBEEF, 1'b1);
    wait_sends(base + 2, 100);
    txErr = 1'b1;
    @(negedge clk);
    txErr = 1'b0;
    drain(200);
    check_count("txerr_flag", int'(errFlag), 1);
    check_count("txerr_sends", sends - base, 5);
  endtask

  task automatic test_burst_wrap();
    int base;
    do_reset();
    base = sends;
    enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      strobe(16'($urandom), 1'b1);
      repeat (59) @(negedge clk);
    end
    drain(3000);
    check_count("burst_sends", sends - base, 1500);
    check_count("burst_dropCount", int'(dropCount), 0);
    check_count("burst_overflow", int'(overflow), 0);
  endtask

  // first strobe is taken straight into the frame register, so 21 strobes fill 16 slots and drop 4
  task automatic test_overflow();
    int base = sends;
    hold_busy = 1'b1;
    for (int i = 0; i < 21; i++) strobe(16'h1000 + 16'(i * 16'h0111), i < 17);
    check_count("ovf_level", int'(fifoLevel), 16);
    check_count("ovf_dropCount", int'(dropCount), 4);
    check_count("ovf_overflow", int'(overflow), 1);
    hold_busy = 1'b0;
    drain(17 * 70);
    check_count("ovf_sends", sends - base, 85);
  endtask

  task automatic test_gating();
    int base = sends;
    hold_busy = 1'b1;
    for (int i = 0; i < 3; i++) strobe(16'hC000 + 16'(i), 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) strobe(16'hDEAD, 1'b0);
    check_count("gate_level", int'(fifoLevel), 2);
    check_count("gate_dropCount", int'(dropCount), 4);
    enable = 1'b1;
    hold_busy = 1'b0;
    drain(400);
    check_count("gate_sends", sends - base, 15);
  endtask

  task automatic test_reset_mid_frame();
    int base = sends;
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) strobe(16'h7700 + 16'(i), 1'b1);
    hold_busy = 1'b0;
    wait_sends(base + 3, 200);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_count("rst_mid_txSend", int'(txSend), 0);
    check_count("rst_mid_level", int'(fifoLevel), 0);
    rst = 1'b0;
    exp_seq = '0;
    @(negedge clk);
    check_count("rst_mid_dropCount", int'(dropCount), 0);
    check_count("rst_mid_overflow", int'(overflow), 0);
    check_count("rst_mid_errFlag", int'(errFlag), 0);
    base = sends;
    strobe(16'h5678, 1'b1);
    drain(200);
    check_count("rst_mid_sends", sends - base, 5);
  endtask

  initial begin
    test_reset();
    test_single();
    test_txerr();
    test_burst_wrap();
    test_overflow();
    test_gating();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
